// File: rtl/mem_bus_scheduler.sv
// Arbitrates fetch and load/store onto one memory port with in-order ID routing.
// Optional MEM_BUS_SCHED_RR_EN: round-robin between masters instead of ram-first.
module mem_bus_scheduler #(
  parameter int          ADDR_W      = 32,
  parameter int          DATA_W      = 32,
  parameter int          MASK_W      = 4,
  parameter int          OUTSTANDING = 2,
  parameter logic [31:0] NOP_INST    = 32'h00000013
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rom_req,
  input  logic [ADDR_W-1:0] rom_address,
  output logic              rom_addr_ok,
  output logic              rom_data_ok,
  output logic [DATA_W-1:0] rom_rdata,
  input  logic              ram_req,
  input  logic              ram_we,
  input  logic [ADDR_W-1:0] ram_address,
  input  logic [DATA_W-1:0] ram_wdata,
  input  logic [MASK_W-1:0] ram_wmask,
  output logic              ram_addr_ok,
  output logic              ram_data_ok,
  output logic [DATA_W-1:0] ram_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [MASK_W-1:0] mem_wmask,
  input  logic              mem_addr_ok,
  input  logic              mem_data_ok,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              err_spurious
);

  localparam int PW =
    (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
  localparam int CW = $clog2(OUTSTANDING) + 1;
  localparam logic [PW-1:0] PTR_LAST =
    PW'(OUTSTANDING - 1);
  localparam logic [CW-1:0] CNT_FULL =
    CW'(OUTSTANDING);

  typedef enum logic {
    ID_ROM = 1'b0,
    ID_RAM = 1'b1
  } mst_e;

  logic          lock_vld;
  mst_e          lock_id;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  mst_e          id_mem [OUTSTANDING];
  logic          err_q;

  logic gnt_vld;
  mst_e gnt_id;
  logic gnt_ram;
  logic gnt_req;
  logic fifo_full;
  logic fifo_empty;
  logic accept;
  logic pop;
  mst_e head_id;

  function automatic logic [PW-1:0] ptr_inc(
    input logic [PW-1:0] p
  );
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

`ifdef MEM_BUS_SCHED_RR_EN
  mst_e rr_last;

  always_comb begin
    gnt_vld = 1'b1;
    gnt_id  = ID_ROM;
    priority case (1'b1)
      lock_vld:
        gnt_id = lock_id;
      ram_req && rom_req:
        gnt_id = (rr_last == ID_RAM) ?
                 ID_ROM : ID_RAM;
      ram_req:
        gnt_id = ID_RAM;
      rom_req:
        gnt_id = ID_ROM;
      default:
        gnt_vld = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      rr_last <= ID_RAM;
    else if (accept)
      rr_last <= gnt_id;
  end
`else
  always_comb begin
    gnt_vld = 1'b1;
    gnt_id  = ID_ROM;
    priority case (1'b1)
      lock_vld: gnt_id = lock_id;
      ram_req:  gnt_id = ID_RAM;
      rom_req:  gnt_id = ID_ROM;
      default:  gnt_vld = 1'b0;
    endcase
  end
`endif

  assign gnt_ram = gnt_vld && (gnt_id == ID_RAM);
  assign gnt_req = gnt_ram ? ram_req :
                   (gnt_vld && rom_req);

  assign fifo_full  = (count == CNT_FULL);
  assign fifo_empty = (count == '0);

  // Full blocks issue even if a pop lands this cycle.
  assign mem_req = gnt_req && !fifo_full;
  assign accept  = mem_req && mem_addr_ok;
  assign pop     = mem_data_ok && !fifo_empty;
  assign head_id = id_mem[rd_ptr];

  assign mem_we      = gnt_ram && ram_we;
  assign mem_address = !gnt_vld ? '0 :
                       gnt_ram  ? ram_address :
                                  rom_address;
  assign mem_wdata   = mem_we ? ram_wdata : '0;
  assign mem_wmask   = mem_we ? ram_wmask : '0;

  assign rom_addr_ok = accept && (gnt_id == ID_ROM);
  assign ram_addr_ok = accept && (gnt_id == ID_RAM);

  assign rom_data_ok = pop && (head_id == ID_ROM);
  assign ram_data_ok = pop && (head_id == ID_RAM);
  assign rom_rdata   = rom_data_ok ? mem_rdata :
                       DATA_W'(NOP_INST);
  assign ram_rdata   = ram_data_ok ? mem_rdata : '0;

  assign err_spurious = err_q;

  // Hold the grant while memory stalls the handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_vld <= 1'b0;
      lock_id  <= ID_ROM;
    end else if (accept) begin
      lock_vld <= 1'b0;
    end else if (mem_req) begin
      lock_vld <= 1'b1;
      lock_id  <= gnt_id;
    end
  end

  always_ff @(posedge clk) begin
    if (accept)
      id_mem[wr_ptr] <= gnt_id;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (accept)
        wr_ptr <= ptr_inc(wr_ptr);
      if (pop)
        rd_ptr <= ptr_inc(rd_ptr);
      unique case ({accept, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      err_q <= 1'b0;
    else if (mem_data_ok && fifo_empty)
      err_q <= 1'b1;
  end

endmodule
